bambu_mem_arbiter_2to1: RTL and testbench

- Serializes the two Bambu master memory channels (packed oe/we/addr/wdata/size buses, channel 0 in the low slice) onto one single-port synchronous RAM.
- RAM write latency is 1 cycle; RAM read latency is a parameter.
- Returns per-channel DataRdy/Rdata using the Bambu handshake. The block sits between the HLS top's Mout_* bus and the off-chip memory model or a real single-port RAM.
- Round-robin arbitration; one transaction in flight at a time.

---
 rtl/bambu_mem_arbiter_2to1_pkg.sv | 19 +
 rtl/bambu_mem_arbiter_2to1_rr_pick2.sv | 19 +
 rtl/bambu_mem_arbiter_2to1.sv | 165 ++++++++++++++++
 tb/tb_bambu_mem_arbiter_2to1.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bambu_mem_arbiter_2to1_pkg.sv
// Shared types, constants and helpers for the 2:1 Bambu memory arbiter.
package bambu_mem_arb_pkg;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // LSB position of channel `ch` inside a packed per-channel bus of slice width `width`.
  function automatic int unsigned ch_lsb(input logic ch, input int unsigned width);
    return ch ? width : 32'd0;
  endfunction

endpackage

// File: rtl/bambu_mem_arbiter_2to1_rr_pick2.sv
// Two-input round-robin picker: one-hot grant, tie broken by the pointer.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_c_o
);

  // Single requester wins outright; on a tie the pointer names the favoured channel.
  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/bambu_mem_arbiter_2to1.sv
// Serialises two Bambu master memory channels onto one single-port synchronous RAM.
module bambu_mem_arbiter_2to1
  import bambu_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SIZE_W   = 4,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [SIZE_W-1:0]        mem_size,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     proto_err
);

  arb_state_e               state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     op_we_q, op_we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [SIZE_W-1:0]        size_q, size_d;
  logic [LAT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     ptr_q, ptr_d;
  logic                     perr_q, perr_d;
  logic                     en_q, en_d;
  logic                     mwe_q, mwe_d;
  logic [N_CH-1:0]          rdy_q, rdy_d;
  logic [N_CH*DATA_W-1:0]   mrdata_q, mrdata_d;
  logic                     busy_q, busy_d;

  logic [N_CH-1:0]          req_c;
  logic [N_CH-1:0]          gnt_c;
  logic                     pick_c;

  // A channel requests only when exactly one of oe/we is raised.
  assign req_c  = Mout_oe_ram ^ Mout_we_ram;
  assign pick_c = gnt_c[1];

  rr_pick2 u_pick (
    .req_i   (req_c),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt_c)
  );

  // State, latched transaction and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      op_we_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ptr_q    <= 1'b0;
      perr_q   <= 1'b0;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      rdy_q    <= '0;
      mrdata_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      op_we_q  <= op_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ptr_q    <= ptr_d;
      perr_q   <= perr_d;
      en_q     <= en_d;
      mwe_q    <= mwe_d;
      rdy_q    <= rdy_d;
      mrdata_q <= mrdata_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; outputs are computed for the state being entered so they register cleanly.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    op_we_d  = op_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ptr_d    = ptr_q;
    en_d     = 1'b0;
    mwe_d    = 1'b0;
    rdy_d    = '0;
    mrdata_d = '0;
    perr_d   = perr_q | (|(Mout_oe_ram & Mout_we_ram));

    case (state_q)
      IDLE: begin
        if (|req_c) begin
          grant_d = pick_c;
          op_we_d = Mout_we_ram[pick_c];
          addr_d  = Mout_addr_ram[ch_lsb(pick_c, ADDR_W) +: ADDR_W];
          wdata_d = Mout_Wdata_ram[ch_lsb(pick_c, DATA_W) +: DATA_W];
          size_d  = Mout_data_ram_size[ch_lsb(pick_c, SIZE_W) +: SIZE_W];
          en_d    = 1'b1;
          mwe_d   = Mout_we_ram[pick_c];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_we_q) begin
          rdy_d[grant_q] = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d   = LAT_W'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          rdata_d                                     = mem_rdata;
          rdy_d[grant_q]                              = 1'b1;
          mrdata_d[ch_lsb(grant_q, DATA_W) +: DATA_W] = mem_rdata;
          state_d                                     = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        ptr_d   = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign M_Rdata_ram = mrdata_q;
  assign M_DataRdy   = rdy_q;
  assign mem_en      = en_q;
  assign mem_we      = mwe_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_size    = size_q;
  assign busy        = busy_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_bambu_mem_arbiter_2to1.sv
// Directed bench for bambu_mem_arbiter_2to1; three builds (READ_LAT 2, 1, 7) share one stimulus.
module tb_bambu_mem_arbiter_2to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [7:0]  size;

  logic        bd_we;
  logic [6:0]  bd_addr;
  logic [7:0]  bd_data;

  logic [15:0] rdata   [3];
  logic [1:0]  rdy     [3];
  logic        m_en    [3];
  logic        m_we    [3];
  logic [6:0]  m_addr  [3];
  logic [7:0]  m_wdata [3];
  logic [3:0]  m_size  [3];
  logic [7:0]  m_rdata [3];
  logic        busy    [3];
  logic        perr    [3];

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] size_mask(input logic [3:0] sz);
    logic [15:0] m;
    m = (16'd1 << sz) - 16'd1;
    return m[7:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [7:0] ram  [128];
    logic [7:0] pipe [8];

    bambu_mem_arbiter_2to1 #(
      .ADDR_W(7), .DATA_W(8), .SIZE_W(4), .READ_LAT(LAT)
    ) u_dut (
      .clock              (clk),
      .reset              (rst_n),
      .Mout_oe_ram        (oe),
      .Mout_we_ram        (we),
      .Mout_addr_ram      (addr),
      .Mout_Wdata_ram     (wdata),
      .Mout_data_ram_size (size),
      .M_Rdata_ram        (rdata[g]),
      .M_DataRdy          (rdy[g]),
      .mem_en             (m_en[g]),
      .mem_we             (m_we[g]),
      .mem_addr           (m_addr[g]),
      .mem_wdata          (m_wdata[g]),
      .mem_size           (m_size[g]),
      .mem_rdata          (m_rdata[g]),
      .busy               (busy[g]),
      .proto_err          (perr[g])
    );

    // RAM model: masked 1-cycle write, LAT-deep read pipeline, garbage when not reading.
    always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (m_en[g] && m_we[g]) ram[m_addr[g]] <= m_wdata[g] & size_mask(m_size[g]);
      pipe[0] <= (m_en[g] && !m_we[g]) ? ram[m_addr[g]] : 8'hEE;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    oe = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic set_req(input logic ch, input logic is_we, input logic [6:0] a, input logic [7:0] d);
    oe    = (!is_we) ? (ch ? 2'b10 : 2'b01) : 2'b00;
    we    = is_we    ? (ch ? 2'b10 : 2'b01) : 2'b00;
    addr  = ch ? {a, 7'h00} : {7'h00, a};
    wdata = ch ? {d, 8'h00} : {8'h00, d};
    size  = ch ? 8'h80 : 8'h08;
  endtask

  // Single write on one channel: ACCESS at cycle 1, DataRdy at cycle 2.
  task automatic wr_ch(input logic ch, input logic [6:0] a, input logic [7:0] d, input string tag);
    set_req(ch, 1'b1, a, d);
    tick();
    chk({tag, "_c1_en"},   32'(m_en[0]), 32'd1);
    chk({tag, "_c1_we"},   32'(m_we[0]), 32'd1);
    chk({tag, "_c1_addr"}, 32'(m_addr[0]), 32'(a));
    chk({tag, "_c1_data"}, 32'(m_wdata[0]), 32'(d));
    tick();
    chk({tag, "_c2_rdy"},  32'(rdy[0]), ch ? 32'd2 : 32'd1);
    idle_inputs();
    tick();
    chk({tag, "_c3_busy"}, 32'(busy[0]), 32'd0);
  endtask

  // Single read on one channel: DataRdy at cycle 4 with data placed in the channel's slice.
  task automatic rd_ch(input logic ch, input logic [6:0] a, input logic [7:0] exp, input string tag);
    set_req(ch, 1'b0, a, 8'h00);
    tick();
    chk({tag, "_c1_en"}, 32'({m_en[0], m_we[0]}), 32'd2);
    tick();
    chk({tag, "_c2_rdy"}, 32'(rdy[0]), 32'd0);
    tick();
    chk({tag, "_c3_rdy"}, 32'(rdy[0]), 32'd0);
    tick();
    chk({tag, "_c4_rdy"},   32'(rdy[0]), ch ? 32'd2 : 32'd1);
    chk({tag, "_c4_rdata"}, 32'(rdata[0]), ch ? 32'({exp, 8'h00}) : 32'({8'h00, exp}));
    idle_inputs();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int first [3];
    logic [7:0] dat [3];

    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    preload(7'h10, 8'h3C);
    preload(7'h01, 8'h11);
    preload(7'h02, 8'h22);

    // Reset state
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_en",   32'(m_en[0]), 32'd0);
    chk("rst_rdy",  32'(rdy[0]), 32'd0);
    chk("rst_addr", 32'(m_addr[0]), 32'd0);
    chk("rst_perr", 32'(perr[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // Ch0 write, then ch1 read of preloaded word, then ch0 readback of the write
    wr_ch(1'b0, 7'h05, 8'hA5, "wr0");
    chk("wr0_size", 32'(m_size[0]), 32'd8);
    rd_ch(1'b1, 7'h10, 8'h3C, "rd1");
    rd_ch(1'b0, 7'h05, 8'hA5, "rd0");

    // Both channels saturated from reset: strict 0,1,0,1 alternation, 5 cycles apart
    do_reset();
    oe = 2'b11; we = 2'b00; addr = {7'd2, 7'd1}; size = 8'h88;
    for (int n = 0; n < 8; n++) begin
      w = 0;
      while (rdy[0] == 2'b00 && w < 20) begin
        tick();
        w++;
      end
      chk("alt_spacing", 32'(w), 32'd4);
      chk("alt_rdy",   32'(rdy[0]), (n % 2 == 1) ? 32'd2 : 32'd1);
      chk("alt_rdata", 32'(rdata[0]), (n % 2 == 1) ? 32'h2200 : 32'h0011);
      tick();
    end
    idle_inputs();
    tick();

    // Protocol error: sticky, no access, subsequent write normal
    chk("perr_pre", 32'(perr[0]), 32'd0);
    oe = 2'b01; we = 2'b01; addr = {7'h0, 7'h20};
    tick();
    chk("perr_set",  32'(perr[0]), 32'd1);
    chk("perr_noen", 32'(m_en[0]), 32'd0);
    chk("perr_busy", 32'(busy[0]), 32'd0);
    wr_ch(1'b0, 7'h20, 8'h5A, "perr_wr");
    chk("perr_sticky", 32'(perr[0]), 32'd1);
    rd_ch(1'b0, 7'h20, 8'h5A, "perr_rd");

    // Reset during WAIT of a ch0 read: outputs clear at once, no DataRdy
    set_req(1'b0, 1'b0, 7'h01, 8'h00);
    tick();
    tick();
    chk("rstw_busy_pre", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy[0]), 32'd0);
    chk("rstw_en",   32'(m_en[0]), 32'd0);
    chk("rstw_rdy",  32'(rdy[0]), 32'd0);
    chk("rstw_addr", 32'(m_addr[0]), 32'd0);
    chk("rstw_perr", 32'(perr[0]), 32'd0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_hold_rdy", 32'(rdy[0]), 32'd0);
    end
    rst_n = 1'b1;
    // Tie right after release: ch0 wins even though ch1 was favoured before reset
    we = 2'b11; addr = {7'h31, 7'h32}; wdata = {8'h77, 8'h88}; size = 8'h88;
    tick();
    chk("tie_addr",  32'(m_addr[0]), 32'h32);
    chk("tie_wdata", 32'(m_wdata[0]), 32'h88);
    tick();
    chk("tie_rdy0", 32'(rdy[0]), 32'd1);
    we = 2'b10;
    tick();
    chk("tie_idle", 32'(busy[0]), 32'd0);
    tick();
    chk("tie_addr1", 32'(m_addr[0]), 32'h31);
    tick();
    chk("tie_rdy1", 32'(rdy[0]), 32'd2);
    idle_inputs();
    tick();

    // Fresh ch1 write, then a ch1 write whose request drops after ACCESS
    wr_ch(1'b1, 7'h30, 8'h66, "wr1");
    set_req(1'b1, 1'b1, 7'h40, 8'h99);
    tick();
    chk("drop_en", 32'(m_en[0]), 32'd1);
    idle_inputs();
    tick();
    chk("drop_rdy", 32'(rdy[0]), 32'd2);
    tick();
    rd_ch(1'b1, 7'h40, 8'h99, "drop_rd");
    rd_ch(1'b0, 7'h32, 8'h88, "tie_rd");

    // Read latency across builds: READ_LAT 2 -> cycle 4, 1 -> cycle 3, 7 -> cycle 9
    do_reset();
    for (int g = 0; g < 3; g++) begin
      first[g] = 0;
      dat[g]   = 8'h00;
    end
    set_req(1'b0, 1'b0, 7'h10, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        if (first[g] == 0 && rdy[g][0]) begin
          first[g] = i;
          dat[g]   = rdata[g][7:0];
        end
      end
    end
    idle_inputs();
    chk("lat2_cycle", 32'(first[0]), 32'd4);
    chk("lat1_cycle", 32'(first[1]), 32'd3);
    chk("lat7_cycle", 32'(first[2]), 32'd9);
    chk("lat2_data",  32'(dat[0]), 32'h3C);
    chk("lat1_data",  32'(dat[1]), 32'h3C);
    chk("lat7_data",  32'(dat[2]), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
